// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory interface for the RV32I core.
// Performs one cache access per request. It formats store lanes and byte
// enables, extends load data, and stalls the pipeline until the access completes.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  store_type,
  input  logic [1:0]  load_type,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mis_q, mis_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  ltype_q, ltype_d;
  logic        luns_q, luns_d;
  logic [1:0]  off_q, off_d;

  logic        req_go;
  logic        is_store;
  logic [1:0]  acc_type;
  logic        acc_mis;

  // Type encoding shared by loads and stores: 1=byte, 2=half, 0/3=word.
  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
    case (typ)
      2'd1:    return 1'b0;
      2'd2:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] typ, input logic [1:0] off);
    case (typ)
      2'd1:    return 4'b0001 << off;
      2'd2:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] typ, input logic [31:0] d);
    case (typ)
      2'd1:    return {4{d[7:0]}};
      2'd2:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [1:0] typ, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (typ)
      2'd1: begin
        ext = b;
        return uns ? {24'b0, b} : ext;
      end
      2'd2: begin
        ext = h;
        return uns ? {16'b0, h} : ext;
      end
      default: return rd;
    endcase
  endfunction

  assign req_go   = req_valid & (req_read | req_write);
  assign is_store = req_write;
  assign acc_type = is_store ? store_type : load_type;
  assign acc_mis  = is_misaligned(acc_type, addr[1:0]);

  assign stall           = req_go & (state_q != DONE);
  assign done            = (state_q == DONE);
  assign misaligned      = done & mis_q;
  assign load_data       = load_data_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'b0;
      mem_be_q      <= 4'b0;
      mem_wdata_q   <= 32'b0;
      mis_q         <= 1'b0;
      load_data_q   <= 32'b0;
      ltype_q       <= 2'b0;
      luns_q        <= 1'b0;
      off_q         <= 2'b0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      mis_q         <= mis_d;
      load_data_q   <= load_data_d;
      ltype_q       <= ltype_d;
      luns_q        <= luns_d;
      off_q         <= off_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for the cache in BUSY, pulse done.
  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    mis_d         = mis_q;
    load_data_d   = load_data_q;
    ltype_d       = ltype_q;
    luns_d        = luns_q;
    off_d         = off_q;
    case (state_q)
      IDLE: begin
        if (req_go) begin
          if (acc_mis) begin
            // Faulting access completes immediately with no bus traffic.
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            mis_d         = 1'b0;
            mem_address_d = {addr[31:2], 2'b00};
            mem_read_d    = ~is_store;
            mem_write_d   = is_store;
            mem_be_d      = is_store ? store_be(store_type, addr[1:0]) : 4'b1111;
            if (is_store) mem_wdata_d = store_data(store_type, wdata);
            ltype_d       = load_type;
            luns_d        = load_unsigned;
            off_d         = addr[1:0];
            state_d       = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) load_data_d = load_format(ltype_q, luns_q, off_q, mem_rdata);
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of accesses driven through a
// scoreboard, plus hand-written reset sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_read, req_write;
  logic [1:0]  store_type, load_type;
  logic        load_unsigned;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned;
  logic [31:0] load_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  st;
    logic [1:0]  lt;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  vec_t tv[17];
  vec_t exp_q[$];

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .store_type(store_type), .load_type(load_type), .load_unsigned(load_unsigned),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .misaligned(misaligned), .load_data(load_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_req();
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    store_type = 2'd0; load_type = 2'd0; load_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  // Called just after a falling edge; drives one access and checks it.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   n;
    logic seen;
    req_valid = 1'b1; req_read = v.rd; req_write = v.wr;
    store_type = v.st; load_type = v.lt; load_unsigned = v.uns;
    addr = v.addr; wdata = v.wdata;
    exp_q.push_back(v);
    @(negedge clk);
    if (!v.mis) begin
      chk("mem_address", mem_address, {v.addr[31:2], 2'b00});
      chk("mem_byte_enable", {28'b0, mem_byte_enable}, {28'b0, v.be});
      if (v.wr) chk("mem_wdata", mem_wdata, v.ewd);
      for (int k = 1; k <= v.lat; k++) begin
        chk("mem_read busy", {31'b0, mem_read}, {31'b0, ~v.wr});
        chk("mem_write busy", {31'b0, mem_write}, {31'b0, v.wr});
        chk("stall busy", {31'b0, stall}, 32'd1);
        chk("done early", {31'b0, done}, 32'd0);
        if (k == v.lat) begin
          mem_resp = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
      end
    end else begin
      chk("mis mem_read", {31'b0, mem_read}, 32'd0);
      chk("mis mem_write", {31'b0, mem_write}, 32'd0);
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 8) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("done seen", {31'b0, seen}, 32'd1);
    chk("done latency", n, 0);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("load_data", load_data, e.ld);
      chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
      chk("stall in DONE", {31'b0, stall}, 32'd0);
      chk("mem_read dropped", {31'b0, mem_read}, 32'd0);
      chk("mem_write dropped", {31'b0, mem_write}, 32'd0);
    end
    clear_req();
    @(negedge clk);
    chk("done one cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    //        rd    wr    st    lt    uns   addr          wdata         rdata         lat be     ewd           ld            mis
    tv[0]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 4'hF, 32'h0,        32'hFFFF_FF80, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2, 4'hF, 32'h0,        32'h0000_0080, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_0000, 1, 4'hF, 32'h0,        32'hFFFF_8001, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_0000, 1, 4'hF, 32'h0,        32'h0000_8001, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_00AB, 32'h0,        2, 4'h2, 32'hABAB_ABAB, 32'h0000_8001, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0000_0202, 32'h1234_CDEF, 32'h0,        1, 4'hC, 32'hCDEF_CDEF, 32'h0000_8001, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0205, 32'h0000_0055, 32'h0,        0, 4'h0, 32'h0,        32'h0000_8001, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0000_8001, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,        32'h1122_3344, 1, 4'hF, 32'h0,        32'h0000_0033, 1'b0};
    tv[10] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0000_0302, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2, 4'h4, 32'h0D0D_0D0D, 32'h0000_0033, 1'b0};
    tv[11] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0000_0104, 32'h0,        32'h1234_5678, 1, 4'hF, 32'h0,        32'h1234_5678, 1'b0};
    tv[12] = '{1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'h0000_F00F, 4, 4'hF, 32'h0,        32'hFFFF_F00F, 1'b0};
    tv[13] = '{1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 32'h0000_0108, 32'h0,        32'hA5A5_A5A5, 1, 4'hF, 32'h0,        32'hA5A5_A5A5, 1'b0};
    tv[14] = '{1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 32'h0000_010A, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'hA5A5_A5A5, 1'b1};
    tv[15] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 32'h0000_040C, 32'h0102_0304, 32'h0,        1, 4'hF, 32'h0102_0304, 32'hA5A5_A5A5, 1'b0};
    tv[16] = '{1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0000_0106, 32'h0,        32'h7FFF_0000, 1, 4'hF, 32'h0,        32'h0000_7FFF, 1'b0};

    rst_n = 1'b0;
    clear_req();
    mem_resp = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset mem_read", {31'b0, mem_read}, 32'd0);
    chk("reset mem_write", {31'b0, mem_write}, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset mem_byte_enable", {28'b0, mem_byte_enable}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset misaligned", {31'b0, misaligned}, 32'd0);
    chk("reset load_data", load_data, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(tv[i]);

    // Stray response while idle must not complete anything.
    mem_resp = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("idle resp done", {31'b0, done}, 32'd0);
    chk("idle resp load_data", load_data, 32'h0000_7FFF);

    // Reset asserted in the middle of a load.
    req_valid = 1'b1; req_read = 1'b1; load_type = 2'd0; addr = 32'h0000_0100;
    @(negedge clk);
    chk("rst seq mem_read up", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst async mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst async mem_address", mem_address, 32'd0);
    chk("rst async done", {31'b0, done}, 32'd0);
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("post-rst stray done", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("post-rst done later", {31'b0, done}, 32'd0);
    chk("post-rst load_data", load_data, 32'd0);
    chk("post-rst mem_read", {31'b0, mem_read}, 32'd0);

    // Unit must be back in IDLE and able to serve a fresh load.
    run_vec(tv[0]);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential data-memory interface for the pipelined RV32I core's MEM stage. Consumes the memory fields of the decoded control word (`write`, `read_b`, `store_type`, `load_type`, `load_unsigned`) together with the ALU-computed address and rs2 data. Runs the request/response handshake with the data cache:
- generates byte enables and lane-aligned store data;
- sign- or zero-extends load data;
- stalls the pipeline until the access completes.

## Interface
Parameters:
- none (RV32I: 32-bit address and data fixed)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  core clock; all state on rising edge
  - `rst_n`  in  1  asynchronous, active-low reset
- Pipeline side:
  - `req_valid`  in  1  MEM stage holds a valid instruction
  - `req_read`  in  1  load (`ctrl.read_b`)
  - `req_write`  in  1  store (`ctrl.write`)
  - `store_type`  in  2  0=sw, 1=sb, 2=sh; 3 treated as sw
  - `load_type`  in  2  0=lw, 1=lb, 2=lh; 3 treated as lw
  - `load_unsigned`  in  1  zero-extend lb/lh
  - `addr`  in  32  byte address
  - `wdata`  in  32  rs2 value
  - `stall`  out  1  pipeline must hold MEM inputs stable
  - `done`  out  1  one-cycle completion pulse
  - `misaligned`  out  1  valid with `done`; access was not performed
  - `load_data`  out  32  formatted load result; held until next completion
- Cache side:
  - `mem_read`  out  1  read request
  - `mem_write`  out  1  write request
  - `mem_address`  out  32  word-aligned address, `{addr[31:2],2'b00}`
  - `mem_byte_enable`  out  4  write lane mask
  - `mem_wdata`  out  32  lane-shifted store data
  - `mem_resp`  in  1  cache completion, single cycle
  - `mem_rdata`  in  32  read word, valid with `mem_resp`

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `req_valid & (req_read | req_write)` and aligned: latch request, assert `mem_read` or `mem_write` (registered), go to BUSY.
  - If misaligned: go to DONE with `misaligned` set and no bus activity.
  - Otherwise: stay in IDLE.
- BUSY:
  - Hold all `mem_*` outputs constant.
  - On `mem_resp`: deassert `mem_read`/`mem_write`, register formatted `load_data` (loads only), go to DONE.
- DONE:
  - `done=1` for exactly one cycle, then unconditionally go to IDLE.
  - Request inputs are ignored in this cycle.
- `stall = req_valid & (req_read | req_write) & (state != DONE)`; combinational.
- `req_read` and `req_write` both set: performed as a store only.
- Misalignment rules:
  - sw/lw: `addr[1:0]!=0`
  - sh/lh: `addr[0]=1`
  - sb/lb: never misaligned
- Store formatting, `off=addr[1:0]`:
  - sb: `mem_byte_enable = 4'b0001<<off`, `mem_wdata = {4{wdata[7:0]}}`
  - sh: `mem_byte_enable = 4'b0011<<off`, `mem_wdata = {2{wdata[15:0]}}`
  - sw: `mem_byte_enable = 4'b1111`, `mem_wdata = wdata`
- Load formatting:
  - lb: byte `mem_rdata[8*off+:8]`
  - lh: half `mem_rdata[16*off[1]+:16]`
  - Extension: sign-extended unless `load_unsigned`.
  - lw: full word.
  - During loads `mem_byte_enable` = 4'b1111.

## Timing
- Reset: state=IDLE; `mem_read`, `mem_write`, `mem_byte_enable`, `mem_address`, `mem_wdata`, `done`, `misaligned`, `load_data` all 0.
- Reset asserted mid-BUSY: requests drop immediately (asynchronously) and the access is abandoned. A later `mem_resp` is ignored.
- Request handshake timing:
  - Request accepted at edge 0; `mem_read`/`mem_write` high from cycle 1.
  - `mem_resp` in cycle k (k≥1); `done` in cycle k+1.
  - Minimum latency: 2 cycles from accept to `done`.
- Misaligned access: `done` and `misaligned` in cycle 1; `stall` low in that cycle.
- `stall` is low in the DONE cycle. The pipeline advances at the following edge and a new request is sampled in IDLE the cycle after. Back-to-back accesses therefore cost ≥3 cycles each.
- `mem_resp` outside BUSY: ignored.
- `load_data` is unchanged by stores and misaligned accesses.

## Test plan
- lw at `0x100`, cache returns `0xDEADBEEF` after 3 cycles:
  - `mem_address=0x100`, `mem_read` high for 3 cycles;
  - `done` in the next cycle; `load_data=0xDEADBEEF`;
  - `stall` low only in the DONE cycle.
- lb at `0x103`, `mem_rdata=0x80FF_1234`: `load_data=0xFFFFFF80`. lbu at the same address: `load_data=0x00000080`.
- lh at `0x102`, `mem_rdata=0x8001_0000`: `load_data=0xFFFF8001`. lhu at the same address: `0x00008001`.
- sb at `0x201`, `wdata=0x000000AB`: `mem_byte_enable=4'b0010`, `mem_wdata=0xABABABAB`, `mem_address=0x200`. sh at `0x202`: `mem_byte_enable=4'b1100`.
- sw at `0x205`: no `mem_write`; `done=1` and `misaligned=1` one cycle after accept. lh at `0x101` behaves the same.
- Reset mid-access:
  - Setup: lw issued; `rst_n` pulled low in cycle 2, before `mem_resp`.
  - During reset: `mem_read=0` immediately.
  - After reset release: state is IDLE; a stray `mem_resp` produces no `done`.
